// File: rtl/crc_req_sched.sv
// Shares one byte-wide CRC step core among NREQ requesters: arbitrate, feed one byte per cycle, post-process, respond.
// Define CRC_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module crc_req_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*32-1:0]   req_data_i,
  input  logic [NREQ*2-1:0]    req_size_i,
  input  logic [NREQ*2-1:0]    req_mode_i,
  input  logic [NREQ-1:0]      req_revin_i,
  input  logic [NREQ-1:0]      req_revout_i,
  input  logic [NREQ*32-1:0]   req_init_i,
  input  logic [NREQ*32-1:0]   req_xorv_i,
  output logic [7:0]           eng_byte_o,
  output logic [1:0]           eng_mode_o,
  output logic [31:0]          eng_crc_o,
  input  logic [31:0]          eng_crc_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [31:0]          rsp_crc_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q;
  logic [IDW-1:0]   grant;
  logic             accept;

  logic [31:0]      data_q, xorv_q, crc_q, res_q;
  logic [1:0]       size_q, mode_q;
  logic             revin_q, revout_q;
  logic [IDW-1:0]   id_q;

  logic [31:0]      sel_data, sel_init, sel_xorv;
  logic [1:0]       sel_size, sel_mode;
  logic             sel_revin, sel_revout;
  logic [7:0]       cur_byte;
  logic [31:0]      next_crc;

  function automatic logic [31:0] crc_mask(input logic [1:0] m);
    case (m)
      2'd0:    crc_mask = 32'h0000_00FF;
      2'd1,
      2'd2:    crc_mask = 32'h0000_FFFF;
      default: crc_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] reflect_w(input logic [31:0] v, input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    case (m)
      2'd0:    for (int i = 0; i < 8; i++)  r[i] = v[7-i];
      2'd1,
      2'd2:    for (int i = 0; i < 16; i++) r[i] = v[15-i];
      default: for (int i = 0; i < 32; i++) r[i] = v[31-i];
    endcase
    return r;
  endfunction

`ifdef CRC_SCHED_RR_EN
  localparam int KW = IDW + 1;
  logic [IDW-1:0] last_q;
  logic [KW-1:0]  rr_idx;
  logic           rr_found;

  // Search begins one past the previous winner and wraps modulo NREQ.
  always_comb begin
    grant    = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rr_idx = {1'b0, last_q} + KW'(i + 1);
      if (rr_idx >= KW'(NREQ)) rr_idx = rr_idx - KW'(NREQ);
      if (!rr_found && req_valid_i[rr_idx[IDW-1:0]]) begin
        grant    = rr_idx[IDW-1:0];
        rr_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) grant = IDW'(i);
    end
  end
`endif

  assign accept = (state_q == IDLE) && (|req_valid_i) && !rst_i;

  always_comb begin
    req_ready_o = '0;
    sel_data    = '0;
    sel_init    = '0;
    sel_xorv    = '0;
    sel_size    = '0;
    sel_mode    = '0;
    sel_revin   = 1'b0;
    sel_revout  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        req_ready_o[i] = accept;
        sel_data       = req_data_i[32*i +: 32];
        sel_init       = req_init_i[32*i +: 32];
        sel_xorv       = req_xorv_i[32*i +: 32];
        sel_size       = req_size_i[2*i +: 2];
        sel_mode       = req_mode_i[2*i +: 2];
        sel_revin      = req_revin_i[i];
        sel_revout     = req_revout_i[i];
      end
    end
  end

  always_comb begin
    case (cnt_q)
      2'd0:    cur_byte = data_q[7:0];
      2'd1:    cur_byte = data_q[15:8];
      2'd2:    cur_byte = data_q[23:16];
      default: cur_byte = data_q[31:24];
    endcase
  end

  assign next_crc   = eng_crc_i & crc_mask(mode_q);
  assign eng_byte_o = (state_q == CALC) ? (revin_q ? reflect8(cur_byte) : cur_byte) : 8'h00;
  assign eng_mode_o = (state_q == IDLE) ? 2'd0 : mode_q;
  assign eng_crc_o  = (state_q == IDLE) ? 32'h0 : crc_q;

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_id_o    = (state_q == RESP) ? id_q : '0;
  assign rsp_crc_o   = (state_q == RESP) ? res_q : 32'h0;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt_q == size_q) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset asynchronously so an in-flight job is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef CRC_SCHED_RR_EN
      last_q  <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
`ifdef CRC_SCHED_RR_EN
        last_q <= grant;
`endif
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Job datapath: outputs are gated by state, so these need no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_q   <= sel_data;
      size_q   <= sel_size;
      mode_q   <= sel_mode;
      revin_q  <= sel_revin;
      revout_q <= sel_revout;
      xorv_q   <= sel_xorv;
      crc_q    <= sel_init & crc_mask(sel_mode);
      id_q     <= grant;
    end else if (state_q == CALC) begin
      crc_q <= next_crc;
      if (cnt_q == size_q)
        res_q <= (revout_q ? reflect_w(next_crc, mode_q) : next_crc) ^ (xorv_q & crc_mask(mode_q));
    end
  end

endmodule
